// File: rtl/bridge_pkg.sv
// bridge_pkg
// Shared definitions for the CPU-to-AXI bridge: read/write FSM state
// encodings, AXI transaction IDs, CPU size encodings and the size mapping
// helper used by both the read path and the write controller.
// Optional feature macro used by the bridge: BRIDGE_RAW_HAZARD_EN.
package bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2
    } wr_state_e;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // CPU size codes map one-to-one onto AXI size codes; size 3 is never
    // issued by the core, so it is passed through unchecked.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/bridge_wr_ctrl.sv
// bridge_wr_ctrl
// Write-side controller of the CPU-to-AXI bridge. Latches one accepted store,
// drives AW and W together, tracks each handshake independently and waits
// for the B response.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   wr_accept              store accepted this cycle (latch req_* payload)
//   req_addr/size/wstrb/wdata  store payload from the CPU data port
//   aw*/w*/b*              AXI write address, data and response handshakes
//   wr_idle                controller is in W_IDLE (can accept a store)
//   b_done                 B handshake happening this cycle
module bridge_wr_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                wr_accept,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic                bvalid,
    output logic                bready,
    output logic                wr_idle,
    output logic                b_done
);
    import bridge_pkg::*;

    wr_state_e            wr_state_q, wr_state_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [1:0]           size_q, size_d;
    logic [DATA_W/8-1:0]  strb_q, strb_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    // State register, handshake flags and latched store payload
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= W_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            addr_q     <= '0;
            size_q     <= 2'd0;
            strb_q     <= '0;
            wdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next-state and flag logic
    always_comb begin
        wr_state_d = wr_state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        addr_d     = addr_q;
        size_d     = size_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_accept) begin
                    wr_state_d = W_REQ;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    addr_d     = req_addr;
                    size_d     = req_size;
                    strb_d     = req_wstrb;
                    wdata_d    = req_wdata;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_REQ: begin
                // Each valid is high exactly while its flag is clear, so a
                // ready seen with the flag clear is that channel's handshake.
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_B;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end else begin
                    wr_state_d = W_REQ;
                end
            end
            W_B: begin
                if (bvalid) begin
                    wr_state_d = W_IDLE;
                end else begin
                    wr_state_d = W_B;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase
    end

    // AXI write-channel outputs decoded from state and flags
    always_comb begin
        awvalid = (wr_state_q == W_REQ) & ~aw_done_q;
        wvalid  = (wr_state_q == W_REQ) & ~w_done_q;
        bready  = (wr_state_q == W_B);
        wr_idle = (wr_state_q == W_IDLE);
        b_done  = (wr_state_q == W_B) & bvalid;
        awaddr  = addr_q;
        awsize  = axi_size(size_q);
        wdata   = wdata_q;
        wstrb   = strb_q;
    end

endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge
// Bridges the CPU's SRAM-like instruction and data ports onto one AXI3
// master. Reads from both ports share a single read FSM (data has priority);
// stores go through bridge_wr_ctrl and may overlap a read.
// Ports:
//   aclk, aresetn                         clock, asynchronous active-low reset
//   inst_*                                fetch port (req/addr in, addr_ok/data_ok/rdata out)
//   data_*                                load/store port (req/wr/size/addr/wdata/wstrb in)
//   ar*/r*                                AXI read address/response channels
//   aw*/w*/b*                             AXI write address/data/response channels
// Optional feature: define BRIDGE_RAW_HAZARD_EN to hold off reads whose word
// address matches a store still in flight.
module cpu_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [3:0]          rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [3:0]          awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [3:0]          wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [3:0]          bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);
    import bridge_pkg::*;

    rd_state_e          r_state_q, r_state_d;
    logic               rd_src_data_q, rd_src_data_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [1:0]         rd_size_q, rd_size_d;
    logic               data_busy_q, data_busy_d;
    logic               inst_data_ok_q, inst_data_ok_d;
    logic               data_data_ok_q, data_data_ok_d;
    logic [DATA_W-1:0]  inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;

    logic data_free_s, data_rd_req_s, data_rd_acc_s, inst_rd_acc_s;
    logic data_wr_acc_s, wr_idle_s, wr_b_done_s, rd_done_s;
    logic inst_raw_s, data_raw_s;
    logic unused_s;

    assign unused_s = ^{rid, rresp, rlast, bid, bresp};

`ifdef BRIDGE_RAW_HAZARD_EN
    // A store is in flight from acceptance until its B handshake.
    assign inst_raw_s = ~wr_idle_s & (inst_addr[ADDR_W-1:2] == awaddr[ADDR_W-1:2]);
    assign data_raw_s = ~wr_idle_s & (data_addr[ADDR_W-1:2] == awaddr[ADDR_W-1:2]);
`else
    assign inst_raw_s = 1'b0;
    assign data_raw_s = 1'b0;
`endif

    // The busy flag drops in the data_ok cycle so a new data request can be
    // accepted back-to-back with the previous response.
    assign data_free_s   = ~data_busy_q | data_data_ok_q;
    assign data_rd_req_s = data_req & ~data_wr;
    assign data_rd_acc_s = (r_state_q == R_IDLE) & data_rd_req_s & data_free_s & ~data_raw_s;
    assign inst_rd_acc_s = (r_state_q == R_IDLE) & inst_req & ~data_rd_req_s & ~inst_raw_s;
    assign data_wr_acc_s = wr_idle_s & data_req & data_wr & data_free_s;
    assign rd_done_s     = (r_state_q == R_R) & rvalid;

    assign inst_addr_ok = inst_rd_acc_s;
    assign data_addr_ok = data_rd_acc_s | data_wr_acc_s;
    assign inst_data_ok = inst_data_ok_q;
    assign data_data_ok = data_data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = ID_DATA;
    assign awlen   = 8'd0;
    assign awburst = 2'd0;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = ID_DATA;
    assign wlast   = 1'b1;

    // Read FSM state register and latched read request
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q     <= R_IDLE;
            rd_src_data_q <= 1'b0;
            rd_addr_q     <= '0;
            rd_size_q     <= 2'd0;
        end else begin
            r_state_q     <= r_state_d;
            rd_src_data_q <= rd_src_data_d;
            rd_addr_q     <= rd_addr_d;
            rd_size_q     <= rd_size_d;
        end
    end

    // Read FSM next state; data read wins over fetch in R_IDLE
    always_comb begin
        r_state_d     = r_state_q;
        rd_src_data_d = rd_src_data_q;
        rd_addr_d     = rd_addr_q;
        rd_size_d     = rd_size_q;
        case (r_state_q)
            R_IDLE: begin
                if (data_rd_acc_s) begin
                    r_state_d     = R_AR;
                    rd_src_data_d = 1'b1;
                    rd_addr_d     = data_addr;
                    rd_size_d     = data_size;
                end else if (inst_rd_acc_s) begin
                    r_state_d     = R_AR;
                    rd_src_data_d = 1'b0;
                    rd_addr_d     = inst_addr;
                    rd_size_d     = SIZE_WORD;
                end else begin
                    r_state_d     = R_IDLE;
                end
            end
            R_AR: begin
                if (arready) begin
                    r_state_d = R_R;
                end else begin
                    r_state_d = R_AR;
                end
            end
            R_R: begin
                if (rvalid) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_R;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Read-channel outputs decoded from the read state
    always_comb begin
        arvalid = (r_state_q == R_AR);
        rready  = (r_state_q == R_R);
        arid    = rd_src_data_q ? ID_DATA : ID_INST;
        araddr  = rd_addr_q;
        arsize  = axi_size(rd_size_q);
    end

    // Response pulses, held read data and data-port busy flag (next values)
    always_comb begin
        inst_data_ok_d = rd_done_s & ~rd_src_data_q;
        data_data_ok_d = (rd_done_s & rd_src_data_q) | wr_b_done_s;
        inst_rdata_d   = (rd_done_s & ~rd_src_data_q) ? rdata : inst_rdata_q;
        data_rdata_d   = (rd_done_s & rd_src_data_q) ? rdata : data_rdata_q;
        if (data_addr_ok) begin
            data_busy_d = 1'b1;
        end else if (data_data_ok_q) begin
            data_busy_d = 1'b0;
        end else begin
            data_busy_d = data_busy_q;
        end
    end

    // Response registers and data-port busy flag
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= '0;
            data_rdata_q   <= '0;
            data_busy_q    <= 1'b0;
        end else begin
            inst_data_ok_q <= inst_data_ok_d;
            data_data_ok_q <= data_data_ok_d;
            inst_rdata_q   <= inst_rdata_d;
            data_rdata_q   <= data_rdata_d;
            data_busy_q    <= data_busy_d;
        end
    end

    bridge_wr_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_ctrl (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .wr_accept (data_wr_acc_s),
        .req_addr  (data_addr),
        .req_size  (data_size),
        .req_wstrb (data_wstrb),
        .req_wdata (data_wdata),
        .awaddr    (awaddr),
        .awsize    (awsize),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready),
        .wr_idle   (wr_idle_s),
        .b_done    (wr_b_done_s)
    );

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge
// Directed testbench for cpu_axi_bridge. The bench plays the AXI slave by
// hand, cycle by cycle; inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge.
module tb_cpu_axi_bridge;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_checks = 0;
    int n_errors = 0;

`ifdef BRIDGE_RAW_HAZARD_EN
    localparam logic RAW = 1'b1;
`else
    localparam logic RAW = 1'b0;
`endif

    always #5 aclk = ~aclk;

    cpu_axi_bridge dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample();
        @(negedge aclk);
    endtask

    initial begin
        aresetn = 1'b0;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_addr = 32'd0; data_wdata = 32'd0; data_wstrb = 4'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd0; bresp = 2'd0; bvalid = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge aclk);
        check_eq("rst_arvalid", arvalid, 1'b0);
        check_eq("rst_awvalid", awvalid, 1'b0);
        check_eq("rst_wvalid", wvalid, 1'b0);
        check_eq("rst_rready", rready, 1'b0);
        check_eq("rst_bready", bready, 1'b0);
        check_eq("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
        check_eq("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        check_eq("rst_inst_rdata", inst_rdata, 32'd0);
        check_eq("rst_data_rdata", data_rdata, 32'd0);
        check_eq("rst_araddr", araddr, 32'd0);
        check_eq("ar_const", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'b01, 2'd0, 4'd0, 3'd0});
        check_eq("aw_const", {awid, awlen, awburst, awlock, awcache, awprot}, {4'd1, 8'd0, 2'd0, 2'd0, 4'd0, 3'd0});
        check_eq("w_const", {wid, wlast}, {4'd1, 1'b1});
        aresetn = 1'b1;
        tick();

        // ---------------- T1: inst read, immediate slave ----------------
        inst_req = 1'b1; inst_addr = 32'hBFC00000; arready = 1'b1;
        sample();
        check_eq("t1_inst_addr_ok", inst_addr_ok, 1'b1);
        check_eq("t1_data_addr_ok", data_addr_ok, 1'b0);
        tick(); inst_req = 1'b0;
        sample();
        check_eq("t1_arvalid", arvalid, 1'b1);
        check_eq("t1_arid", arid, 4'd0);
        check_eq("t1_araddr", araddr, 32'hBFC00000);
        check_eq("t1_arsize", arsize, 3'd2);
        tick(); rvalid = 1'b1; rdata = 32'h3C080001;
        sample();
        check_eq("t1_rready", rready, 1'b1);
        check_eq("t1_arvalid_off", arvalid, 1'b0);
        tick(); rvalid = 1'b0; rdata = 32'd0;
        sample();
        check_eq("t1_inst_data_ok", inst_data_ok, 1'b1);
        check_eq("t1_inst_rdata", inst_rdata, 32'h3C080001);
        check_eq("t1_data_data_ok", data_data_ok, 1'b0);
        tick();
        sample();
        check_eq("t1_ok_pulse_end", inst_data_ok, 1'b0);
        check_eq("t1_rdata_hold", inst_rdata, 32'h3C080001);
        tick();

        // ---------------- T2: inst + data read same cycle ----------------
        inst_req = 1'b1; inst_addr = 32'hBFC00004;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000010; data_size = 2'd2;
        sample();
        check_eq("t2_data_addr_ok", data_addr_ok, 1'b1);
        check_eq("t2_inst_addr_ok", inst_addr_ok, 1'b0);
        tick(); data_req = 1'b0;
        sample();
        check_eq("t2_first_arid", arid, 4'd1);
        check_eq("t2_first_araddr", araddr, 32'h80000010);
        check_eq("t2_inst_wait", inst_addr_ok, 1'b0);
        tick(); rvalid = 1'b1; rdata = 32'h11223344;
        sample();
        tick(); rvalid = 1'b0;
        sample();
        check_eq("t2_data_data_ok", data_data_ok, 1'b1);
        check_eq("t2_data_rdata", data_rdata, 32'h11223344);
        check_eq("t2_inst_now_ok", inst_addr_ok, 1'b1);
        tick(); inst_req = 1'b0;
        sample();
        check_eq("t2_second_arvalid", arvalid, 1'b1);
        check_eq("t2_second_arid", arid, 4'd0);
        check_eq("t2_second_araddr", araddr, 32'hBFC00004);
        tick(); rvalid = 1'b1; rdata = 32'h27BDFFF0;
        sample();
        tick(); rvalid = 1'b0;
        sample();
        check_eq("t2_inst_data_ok", inst_data_ok, 1'b1);
        check_eq("t2_inst_rdata", inst_rdata, 32'h27BDFFF0);
        tick();

        // ---------------- T3: byte store, wready 3 cycles late ----------------
        awready = 1'b1; wready = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h80000003;
        data_wstrb = 4'b1000; data_wdata = 32'hAB000000;
        sample();
        check_eq("t3_addr_ok", data_addr_ok, 1'b1);
        tick(); data_req = 1'b0; data_wr = 1'b0;
        sample();
        check_eq("t3_aw_w_valid", {awvalid, wvalid}, 2'b11);
        check_eq("t3_awsize", awsize, 3'd0);
        check_eq("t3_awaddr", awaddr, 32'h80000003);
        check_eq("t3_wstrb", wstrb, 4'b1000);
        tick(); awready = 1'b0;
        sample();
        check_eq("t3_aw_dropped", {awvalid, wvalid, bready}, 3'b010);
        tick();
        sample();
        check_eq("t3_still_wait", {wvalid, bready}, 2'b10);
        tick(); wready = 1'b1;
        sample();
        check_eq("t3_w_hs_cycle", {wvalid, bready}, 2'b10);
        check_eq("t3_wdata", wdata, 32'hAB000000);
        tick(); wready = 1'b0; bvalid = 1'b1;
        sample();
        check_eq("t3_in_w_b", {wvalid, bready}, 2'b01);
        tick(); bvalid = 1'b0;
        sample();
        check_eq("t3_data_ok", data_data_ok, 1'b1);
        tick();
        sample();
        check_eq("t3_data_ok_end", data_data_ok, 1'b0);
        tick();

        // ---------------- T4: store with late B while a fetch completes ----------------
        awready = 1'b1; wready = 1'b1;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h80000100;
        data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF;
        inst_req = 1'b1; inst_addr = 32'hBFC00008;
        sample();
        check_eq("t4_both_accept", {data_addr_ok, inst_addr_ok}, 2'b11);
        tick(); data_req = 1'b0; data_wr = 1'b0; inst_req = 1'b0;
        sample();
        check_eq("t4_aw_w_ar", {awvalid, wvalid, arvalid}, 3'b111);
        check_eq("t4_arid", arid, 4'd0);
        tick(); rvalid = 1'b1; rdata = 32'h24020005;
        sample();
        check_eq("t4_bready_rready", {bready, rready}, 2'b11);
        tick(); rvalid = 1'b0;
        sample();
        check_eq("t4_inst_data_ok", inst_data_ok, 1'b1);
        check_eq("t4_inst_rdata", inst_rdata, 32'h24020005);
        check_eq("t4_no_data_ok", data_data_ok, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            check_eq("t4_b_wait", {data_data_ok, bready}, 2'b01);
        end
        tick(); bvalid = 1'b1;
        sample();
        check_eq("t4_bvalid_cycle", data_data_ok, 1'b0);
        tick(); bvalid = 1'b0;
        sample();
        check_eq("t4_data_ok", data_data_ok, 1'b1);
        tick();
        sample();
        check_eq("t4_data_ok_end", data_data_ok, 1'b0);
        tick();

        // ---------------- T5: reads against a pending store to 0x80000000 ----------------
        arready = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h80000000;
        data_wstrb = 4'hF; data_wdata = 32'h12345678;
        sample();
        check_eq("t5_st_accept", data_addr_ok, 1'b1);
        tick(); data_req = 1'b0; data_wr = 1'b0; inst_req = 1'b1; inst_addr = 32'h80000000;
        sample();
        check_eq("t5_raw_inst", inst_addr_ok, !RAW);
        tick(); inst_req = 1'b0; arready = 1'b1;
        sample();
        tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE0001;
        sample();
        tick(); rvalid = 1'b0;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000000; data_size = 2'd2;
        sample();
        check_eq("t5_raw_inst_done", inst_data_ok, !RAW);
        check_eq("t5_ld_blocked0", data_addr_ok, 1'b0);
        tick();
        sample();
        check_eq("t5_ld_blocked1", data_addr_ok, 1'b0);
        tick(); bvalid = 1'b1;
        sample();
        check_eq("t5_ld_blocked_b", data_addr_ok, 1'b0);
        tick(); bvalid = 1'b0;
        sample();
        check_eq("t5_st_data_ok", data_data_ok, 1'b1);
        check_eq("t5_ld_accept", data_addr_ok, 1'b1);
        tick(); data_req = 1'b0; arready = 1'b1;
        sample();
        check_eq("t5_ld_ar", {arvalid, arid}, {1'b1, 4'd1});
        check_eq("t5_ld_araddr", araddr, 32'h80000000);
        tick(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h5555AAAA;
        sample();
        tick(); rvalid = 1'b0;
        sample();
        check_eq("t5_ld_data_ok", data_data_ok, 1'b1);
        check_eq("t5_ld_rdata", data_rdata, 32'h5555AAAA);
        tick();

        // ---------------- T6: reset while in R_AR ----------------
        arready = 1'b0;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80000020; data_size = 2'd2;
        sample();
        check_eq("t6_accept", data_addr_ok, 1'b1);
        tick(); data_req = 1'b0;
        sample();
        check_eq("t6_arvalid", arvalid, 1'b1);
        #2; aresetn = 1'b0;
        #1;
        check_eq("t6_async_clear", arvalid, 1'b0);
        tick();
        sample();
        check_eq("t6_in_reset", {arvalid, data_data_ok}, 2'b00);
        aresetn = 1'b1;
        tick(); rvalid = 1'b1; rdata = 32'h0BADF00D; arready = 1'b1;
        sample();
        check_eq("t6_idle_after", {arvalid, rready, data_data_ok}, 3'b000);
        tick(); rvalid = 1'b0;
        sample();
        check_eq("t6_no_data_ok", data_data_ok, 1'b0);
        check_eq("t6_rdata_reset", data_rdata, 32'd0);
        tick();
        data_req = 1'b1; data_addr = 32'h80000024;
        sample();
        check_eq("t6_next_accept", data_addr_ok, 1'b1);
        tick(); data_req = 1'b0;
        sample();
        check_eq("t6_next_ar", {arvalid, arid}, {1'b1, 4'd1});
        check_eq("t6_next_araddr", araddr, 32'h80000024);
        tick(); rvalid = 1'b1; rdata = 32'h76543210;
        sample();
        tick(); rvalid = 1'b0; arready = 1'b0;
        sample();
        check_eq("t6_next_data_ok", data_data_ok, 1'b1);
        check_eq("t6_next_rdata", data_rdata, 32'h76543210);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
